// File: rtl/bubble_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_ctrl (with helper pair_swap)
// Brief    : Loads DIM unsigned elements, bubble-sorts them in place with one
//            shared compare-exchange unit (early exit on a swap-free pass),
//            then streams them out in ascending order.
// Revision : 1.0 - initial release
// ============================================================================

// Single unsigned compare-exchange: routes the pair to (smaller, larger).
module pair_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] smaller,
  output logic [WIDTH-1:0] larger
);
  logic w_gt;
  assign w_gt    = (a > b);
  assign smaller = w_gt ? b : a;
  assign larger  = w_gt ? a : b;
endmodule

module bubble_sort_ctrl #(
  parameter int DIM   = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      cmp_cycles
);
  localparam int IW = (DIM > 2) ? $clog2(DIM) : 1;
  // Index of the last element, and the last j of the first pass.
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DIM - 1);
  localparam logic [IW-1:0] C_LAST_J   = IW'(DIM - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DIM];
  logic [IW-1:0]    wr_idx_q;
  logic [IW-1:0]    rd_idx_q;
  logic [IW-1:0]    p_q;
  logic [IW-1:0]    j_q;
  logic             swap_q;
  logic [15:0]      cmp_q;
  logic [15:0]      cmp_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [IW-1:0]    w_j1;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_small;
  logic [WIDTH-1:0] w_large;
  logic             w_swap;
  logic             w_pass_end;
  logic             w_pass_swapped;

  assign w_j1           = j_q + 1'b1;
  assign w_a            = mem_q[j_q];
  assign w_b            = mem_q[w_j1];
  // Equal elements are left alone and do not count as a swap.
  assign w_swap         = (w_a > w_b);
  // Each pass is one shorter than the previous: the tail is already in place.
  assign w_pass_end     = (j_q == (C_LAST_J - p_q));
  assign w_pass_swapped = swap_q | w_swap;
  assign cmp_d          = (cmp_q == 16'hFFFF) ? cmp_q : (cmp_q + 16'd1);

  pair_swap #(.WIDTH(WIDTH)) u_pair_swap (
    .a       (w_a),
    .b       (w_b),
    .smaller (w_small),
    .larger  (w_large)
  );

  // Control FSM: LOAD -> SORT -> DRAIN -> LOAD, outputs registered with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      p_q         <= '0;
      j_q         <= '0;
      swap_q      <= 1'b0;
      cmp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            if (wr_idx_q == C_LAST_IDX) begin
              state_q    <= ST_SORT;
              wr_idx_q   <= '0;
              p_q        <= '0;
              j_q        <= '0;
              swap_q     <= 1'b0;
              cmp_q      <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        ST_SORT: begin
          cmp_q <= cmp_d;
          if (w_pass_end) begin
            // A clean pass means the array is sorted; the last pass ends anyway.
            if (!w_pass_swapped || (p_q == C_LAST_J)) begin
              state_q     <= ST_DRAIN;
              rd_idx_q    <= '0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              p_q    <= p_q + 1'b1;
              j_q    <= '0;
              swap_q <= 1'b0;
            end
          end else begin
            j_q    <= w_j1;
            swap_q <= w_pass_swapped;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_idx_q == C_LAST_IDX) begin
              state_q     <= ST_LOAD;
              wr_idx_q    <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          wr_idx_q    <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Element storage: written on load and by the compare-exchange; never reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if ((state_q == ST_LOAD) && in_valid) begin
        mem_q[wr_idx_q] <= in_data;
      end else if (state_q == ST_SORT) begin
        mem_q[j_q]  <= w_small;
        mem_q[w_j1] <= w_large;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign cmp_cycles = cmp_q;
  assign out_data   = mem_q[rd_idx_q];

endmodule
`default_nettype wire

// File: doc/bubble_sort_ctrl.md
BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 The block SHALL take parameter DIM, default 8: number of elements sorted per job (DIM >= 2).
REQ-002 The block SHALL take parameter WIDTH, default 8: element width in bits, unsigned.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the element on in_data is offered.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the unsorted element.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a sorted element.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the sorted element, ascending order.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-011 The block SHALL have port busy, output, 1 bit: a sort is in progress.
REQ-012 The block SHALL have port cmp_cycles, output, 16 bits: compare-exchange cycles spent on the last job.

Function
REQ-013 The block SHALL hold DIM×WIDTH element storage and instantiate exactly one pair_swap #(WIDTH) as its only comparator: inputs mem[j], mem[j+1]; outputs smaller, larger (unsigned).
REQ-014 The FSM SHALL have states LOAD, SORT and DRAIN; reset enters LOAD.
REQ-015 LOAD: in_ready=1, out_valid=0, busy=0; each cycle with in_valid=1, mem[wr_idx]<=in_data and wr_idx increments.
REQ-016 On the DIM-th accepted element, the FSM SHALL enter SORT on the next cycle with in_ready=0, pass p=0, index j=0, swap flag cleared and cmp_cycles cleared.
REQ-017 SORT: busy=1 and in_ready=0; each cycle, mem[j]<=smaller, mem[j+1]<=larger, and cmp_cycles increments (saturating at 16'hFFFF).
REQ-018 The swap flag SHALL set only when mem[j] > mem[j+1] strictly; equal elements do not count as a swap.
REQ-019 The pass end is j == DIM-2-p; otherwise j increments.
REQ-020 At the pass end, the FSM SHALL enter DRAIN if no swap occurred in this pass (including this cycle) or if p == DIM-2; otherwise p increments, j=0 and the flag clears.
REQ-021 Compare count: sorted input = DIM-1 cycles; reverse-sorted input = DIM*(DIM-1)/2 cycles.
REQ-022 DRAIN: out_valid=1, out_data=mem[rd_idx], rd_idx starts at 0; rd_idx increments on out_valid && out_ready.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On the DIM-th accepted output, the FSM SHALL return to LOAD on the next cycle with wr_idx=0.
REQ-025 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.
REQ-026 cmp_cycles SHALL hold its value through DRAIN and the following LOAD until the next SORT entry.
REQ-027 Output order SHALL be non-decreasing; the output multiset SHALL equal the input multiset.

Reset
REQ-028 While rst_n=0 at a clk edge: state=LOAD, wr_idx=rd_idx=p=j=0, swap flag=0, cmp_cycles=0.
REQ-029 Reset outputs: in_ready=1, out_valid=0, busy=0, cmp_cycles=0; out_data is don't-care while out_valid=0.
REQ-030 Element storage SHALL NOT be reset; its contents after reset are unspecified and never appear with out_valid=1.
REQ-031 Reset during LOAD, SORT or DRAIN SHALL abandon the job with no partial output; the next full load SHALL sort correctly.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, cmp_cycles=0.
REQ-033 Load 7,6,5,4,3,2,1,0 (DIM=8, WIDTH=8), out_ready=1 -> cmp_cycles=28, busy high 28 cycles, outputs 0..7.
REQ-034 Load 0,1,2,...,7 -> cmp_cycles=7 (single pass), outputs 0..7.
REQ-035 Load 5,5,3,3,255,0,5,3 -> outputs 0,3,3,3,5,5,5,255.
REQ-036 Random out_ready toggling plus in_valid=1 held during SORT/DRAIN -> no element lost or duplicated, out_data stable while stalled, no extra loads.
REQ-037 rst_n=0 for 1 cycle mid-SORT -> next cycle in_ready=1, busy=0, out_valid=0; a following load of 9,1,8,2,7,3,6,4 outputs 1,2,3,4,6,7,8,9.
